// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM encoding and accumulator sizing for the SAR controller.
package sar_pkg;

    typedef enum logic [2:0] {IDLE, SAMPLE, CMP, SETTLE, DONE} state_t;

    function automatic int acc_width(input int nbits, input int avg_log2);
        return nbits + avg_log2;
    endfunction

endpackage

// File: rtl/sar_avg_acc.sv
// sar_avg_acc: sums 2^AVG_LOG2 conversion codes and publishes the truncated mean with an eoc pulse.
module sar_avg_acc
    import sar_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int AVG_LOG2 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic [NBITS-1:0] code,
    output logic [NBITS-1:0] sar,
    output logic             eoc
);

    localparam int AW = acc_width(NBITS, AVG_LOG2);
    localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]     acc;
    logic [AVG_LOG2:0] cnt;
    logic [AW-1:0]     sum;
    logic              wrap;

    assign sum  = acc + AW'(code);
    assign wrap = cnt == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            sar <= '0;
            eoc <= 1'b0;
        end else begin
            eoc <= 1'b0;
            if (fire) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                acc <= wrap ? '0 : sum;
                if (wrap) begin
                    sar <= sum[AVG_LOG2 +: NBITS];
                    eoc <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sar_logic_nb.sv
// sar_logic_nb: SAR conversion sequencer with differential DAC switch drive,
// continuous mode and optional averaging of 2^AVG_LOG2 conversions.
module sar_logic_nb
    import sar_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int SAMPLE_CYC = 2,
    parameter int AVG_LOG2   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnvst,
    input  logic             cont,
    input  logic             cmp_out,
    output logic [NBITS-1:0] sar,
    output logic             eoc,
    output logic             busy,
    output logic             cmp_clk,
    output logic             s_clk,
    output logic [NBITS-1:0] dacp_top,
    output logic [NBITS-1:0] dacp_btm,
    output logic [NBITS-1:0] dacn_top,
    output logic [NBITS-1:0] dacn_btm
);

    localparam int KW = $clog2(NBITS);
    localparam int SW = $clog2(SAMPLE_CYC + 1);

    state_t           state, nstate;
    logic [KW-1:0]    k, nk;
    logic [SW-1:0]    scnt, nscnt;
    logic [NBITS-1:0] code, ncode, npt, npb, nnt, nnb;
    logic             fire;

    // code is complete on the edge that enters DONE
    assign fire = (state == SETTLE) && (k == '0);

    always_comb begin
        nstate = state;
        nk     = k;
        nscnt  = scnt;
        ncode  = code;
        npt    = dacp_top;
        npb    = dacp_btm;
        nnt    = dacn_top;
        nnb    = dacn_btm;
        case (state)
            IDLE: begin
                nstate = cnvst ? SAMPLE : IDLE;
                nscnt  = '0;
            end
            SAMPLE: begin
                nstate = (scnt == SW'(SAMPLE_CYC - 1)) ? CMP : SAMPLE;
                nscnt  = scnt + 1'b1;
                nk     = KW'(NBITS - 1);
                ncode  = '0;
            end
            CMP: begin
                nstate   = SETTLE;
                ncode[k] = cmp_out;
                npb[k]   = cmp_out;
                nnt[k]   = cmp_out;
                npt[k]   = !cmp_out;
                nnb[k]   = !cmp_out;
            end
            SETTLE: begin
                nstate = (k == '0) ? DONE : CMP;
                nk     = k - 1'b1;
            end
            DONE: begin
                // eoc low here means the averaging group still needs conversions
                nstate = (!eoc || cont) ? SAMPLE : IDLE;
                nscnt  = '0;
            end
            default: nstate = IDLE;
        endcase
        if (nstate == SAMPLE) begin
            npt = '0;
            npb = '0;
            nnt = '0;
            nnb = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            scnt     <= '0;
            code     <= '0;
            busy     <= 1'b0;
            cmp_clk  <= 1'b0;
            s_clk    <= 1'b0;
            dacp_top <= '0;
            dacp_btm <= '0;
            dacn_top <= '0;
            dacn_btm <= '0;
        end else begin
            state    <= nstate;
            k        <= nk;
            scnt     <= nscnt;
            code     <= ncode;
            busy     <= nstate != IDLE;
            cmp_clk  <= nstate == CMP;
            s_clk    <= nstate == SAMPLE;
            dacp_top <= npt;
            dacp_btm <= npb;
            dacn_top <= nnt;
            dacn_btm <= nnb;
        end
    end

    sar_avg_acc #(.NBITS(NBITS), .AVG_LOG2(AVG_LOG2)) u_avg (
        .clk (clk),
        .rst (rst),
        .fire(fire),
        .code(ncode),
        .sar (sar),
        .eoc (eoc)
    );

endmodule

// File: tb/tb_sar_logic_nb.sv
// tb_sar_logic_nb: scoreboard bench for sar_logic_nb, default instance plus an AVG_LOG2=2 instance.
module tb_sar_logic_nb;

    logic       clk = 0, rst = 1;
    logic       cnvst = 0, cont = 0, cmp_out;
    logic [7:0] sar, dacp_top, dacp_btm, dacn_top, dacn_btm;
    logic       eoc, busy, cmp_clk, s_clk;
    logic       cnvst_a = 0, cmp_a;
    logic [7:0] sar_a, pt_a, pb_a, nt_a, nb_a;
    logic       eoc_a, busy_a, cmpclk_a, sclk_a;

    logic       const1 = 0;
    logic [7:0] vin = 0, vin_a = 0;
    int         checks = 0, errors = 0;
    int         cyc = 0, eoc_cnt = 0, eoc_a_cnt = 0, ovl = 0;
    logic [7:0] exp_q[$], exp_a_q[$];

    always #5 clk = ~clk;

    sar_logic_nb dut (
        .clk(clk), .rst(rst), .cnvst(cnvst), .cont(cont), .cmp_out(cmp_out),
        .sar(sar), .eoc(eoc), .busy(busy), .cmp_clk(cmp_clk), .s_clk(s_clk),
        .dacp_top(dacp_top), .dacp_btm(dacp_btm), .dacn_top(dacn_top), .dacn_btm(dacn_btm)
    );

    sar_logic_nb #(.AVG_LOG2(2)) dut_avg (
        .clk(clk), .rst(rst), .cnvst(cnvst_a), .cont(1'b0), .cmp_out(cmp_a),
        .sar(sar_a), .eoc(eoc_a), .busy(busy_a), .cmp_clk(cmpclk_a), .s_clk(sclk_a),
        .dacp_top(pt_a), .dacp_btm(pb_a), .dacn_top(nt_a), .dacn_btm(nb_a)
    );

    // Comparator model: trial level = decided ones plus the highest undecided bit
    function automatic logic [7:0] trial(input logic [7:0] top, input logic [7:0] btm);
        logic [7:0] t = btm;
        for (int i = 0; i < 8; i++)
            if (!top[i] && !btm[i]) t = btm | (8'd1 << i);
        return t;
    endfunction

    assign cmp_out = const1 ? 1'b1 : (vin >= trial(dacp_top, dacp_btm));
    assign cmp_a   = vin_a >= trial(pt_a, pb_a);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eoc) eoc_cnt <= eoc_cnt + 1;
        if (eoc_a) eoc_a_cnt <= eoc_a_cnt + 1;
        if ((dacp_top & dacp_btm) != 0 || (dacn_top & dacn_btm) != 0 ||
            (pt_a & pb_a) != 0 || (nt_a & nb_a) != 0) ovl <= ovl + 1;
    end

    task automatic wait_eoc(input int maxc, output logic got);
        got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            got = eoc;
        end
    endtask

    task automatic pulse_cnvst();
        @(negedge clk) cnvst = 1;
        @(posedge clk) #1 cnvst = 0;
    endtask

    task automatic test_reset();
        int e0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        e0 = eoc_cnt;
        checks++;
        if ({sar, eoc, busy, cmp_clk, s_clk, dacp_top, dacp_btm, dacn_top, dacn_btm} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b s_clk=%b cmp_clk=%b sar=%h, want all 0", busy, s_clk, cmp_clk, sar);
        end
        checks++;
        if ({sar_a, eoc_a, busy_a, cmpclk_a, sclk_a, pt_a, pb_a, nt_a, nb_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_avg: got busy=%b sar=%h, want all 0", busy_a, sar_a);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (busy !== 0 || eoc_cnt != e0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b eocs=%0d, want busy=0 eocs=0", busy, eoc_cnt - e0);
        end
    endtask

    task automatic test_all_ones();
        logic [1:0] exp_ctl;
        logic [7:0] exp;
        const1 = 1;
        @(negedge clk) cnvst = 1;
        exp_q.push_back(8'hFF);
        @(posedge clk) #1 cnvst = 0;
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            exp_ctl = {n < 2, n >= 2 && (n % 2) == 0};
            checks++;
            if ({s_clk, cmp_clk} !== exp_ctl || eoc !== 0) begin
                errors++;
                $display("FAIL ones_seq n=%0d: got s_clk,cmp_clk,eoc=%b%b%b, want %b0", n, s_clk, cmp_clk, eoc, exp_ctl);
            end
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (eoc !== 1 || sar !== exp) begin
            errors++;
            $display("FAIL ones_eoc: got eoc=%b sar=%h at edge 18, want eoc=1 sar=%h", eoc, sar, exp);
        end
        checks++;
        if ({dacp_btm, dacn_top, dacp_top, dacn_btm} !== {8'hFF, 8'hFF, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL ones_dac: got pb=%h nt=%h pt=%h nb=%h, want FF FF 00 00", dacp_btm, dacn_top, dacp_top, dacn_btm);
        end
        @(negedge clk);
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL ones_idle: got busy=%b, want 0", busy);
        end
        const1 = 0;
    endtask

    task automatic test_model_5a();
        logic got;
        logic [7:0] exp;
        vin = 8'h5A;
        exp_q.push_back(vin);
        pulse_cnvst();
        wait_eoc(40, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || sar !== exp) begin
            errors++;
            $display("FAIL model_sar: got eoc=%b sar=%h, want eoc=1 sar=%h", got, sar, exp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({dacp_btm, dacn_top, dacp_top, dacn_btm} !== {8'h5A, 8'h5A, 8'hA5, 8'hA5}) begin
            errors++;
            $display("FAIL model_dac_hold: got pb=%h nt=%h pt=%h nb=%h, want 5A 5A A5 A5", dacp_btm, dacn_top, dacp_top, dacn_btm);
        end
    endtask

    task automatic test_continuous();
        logic got;
        logic [7:0] exp;
        int t_prev, e0;
        vin = 8'h33;
        cont = 1;
        pulse_cnvst();
        t_prev = -1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vin);
            if (i == 4) cont = 0;
            wait_eoc(40, got);
            exp = exp_q.pop_front();
            checks++;
            if (!got || sar !== exp) begin
                errors++;
                $display("FAIL cont_sar[%0d]: got eoc=%b sar=%h, want eoc=1 sar=%h", i, got, sar, exp);
            end
            if (t_prev >= 0) begin
                checks++;
                if (cyc - t_prev !== 19) begin
                    errors++;
                    $display("FAIL cont_period[%0d]: got %0d cycles, want 19", i, cyc - t_prev);
                end
            end
            t_prev = cyc;
            if (i < 4) begin
                repeat (5) @(negedge clk);
                cnvst = 1;
                @(negedge clk) cnvst = 0;
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL cont_stop_busy: got %b, want 0", busy);
        end
        e0 = eoc_cnt;
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (eoc_cnt != e0 || busy !== 0) begin
            errors++;
            $display("FAIL cont_stop_quiet: got %0d extra eocs busy=%b, want 0 and 0", eoc_cnt - e0, busy);
        end
    endtask

    task automatic test_abort();
        logic got;
        logic [7:0] exp;
        vin = 8'h77;
        exp_q.push_back(vin);
        @(negedge clk) cnvst = 1;
        @(posedge clk) #1 cnvst = 0;
        repeat (9) @(negedge clk);
        checks++;
        if (cmp_clk !== 1 || dacp_top[7:5] !== 3'b100) begin
            errors++;
            $display("FAIL abort_bit4: got cmp_clk=%b pt=%h, want cmp_clk=1 pt[7:5]=100", cmp_clk, dacp_top);
        end
        #1 rst = 1;
        void'(exp_q.pop_back());
        #1;
        checks++;
        if ({sar, eoc, busy, cmp_clk, s_clk, dacp_top, dacp_btm, dacn_top, dacn_btm} !== '0) begin
            errors++;
            $display("FAIL abort_async: got busy=%b cmp_clk=%b sar=%h pt=%h pb=%h, want all 0", busy, cmp_clk, sar, dacp_top, dacp_btm);
        end
        @(posedge clk);
        @(negedge clk) rst = 0;
        vin = 8'hC3;
        exp_q.push_back(vin);
        pulse_cnvst();
        wait_eoc(40, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || sar !== exp) begin
            errors++;
            $display("FAIL abort_recover: got eoc=%b sar=%h, want eoc=1 sar=%h", got, sar, exp);
        end
    endtask

    task automatic test_average();
        int n, e0;
        logic [7:0] exp;
        vin_a = 8'd10;
        exp_a_q.push_back(8'd11);
        e0 = eoc_a_cnt;
        @(negedge clk) cnvst_a = 1;
        @(posedge clk) #1 cnvst_a = 0;
        n = 0;
        while (n < 120) begin
            @(negedge clk);
            if (eoc_a) break;
            if (n == 19 || n == 38 || n == 57) vin_a = vin_a + 8'd1;
            n++;
        end
        exp = exp_a_q.pop_front();
        checks++;
        if (eoc_a !== 1 || n != 75 || eoc_a_cnt != e0) begin
            errors++;
            $display("FAIL avg_timing: got eoc at cycle %0d (earlier eocs %0d), want 75 and 0", n, eoc_a_cnt - e0);
        end
        checks++;
        if (sar_a !== exp) begin
            errors++;
            $display("FAIL avg_sar: got %0d, want %0d", sar_a, exp);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 0) begin
            errors++;
            $display("FAIL avg_idle: got busy=%b, want 0", busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_model_5a();
        test_continuous();
        test_abort();
        test_average();
        #1;
        checks++;
        if (ovl !== 0) begin
            errors++;
            $display("FAIL top_btm_overlap: got %0d cycles with top&btm set, want 0", ovl);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_logic_nb.md
Name: sar_logic_nb

Overview:
Parametrised successor to the 8-bit SAR controller. It sequences sampling and the bit-by-bit binary search, and drives differential top/bottom DAC switch vectors for both capacitor arrays. Beyond single-shot conversion, it adds a continuous-conversion mode and optional on-chip averaging of 2^AVG_LOG2 conversions. It sits between the comparator/cap-DAC analog macro and the digital readout.

Parameters:
NBITS, 8, resolution; width of result and of each DAC switch vector (≥2).
SAMPLE_CYC, 2, clk cycles s_clk is held high for tracking (≥1).
AVG_LOG2, 0, log2 of conversions averaged per reported result (0 = no averaging).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
cnvst  in  1  conversion start; sampled high in IDLE starts a result.
cont  in  1  continuous mode; sampled in DONE.
cmp_out  in  1  comparator decision; 1 = Vp > Vn.
sar  out  NBITS  last completed (averaged) result; held until next eoc.
eoc  out  1  end of conversion; 1-cycle pulse, sar valid in same cycle.
busy  out  1  high in any state except IDLE.
cmp_clk  out  1  comparator strobe.
s_clk  out  1  sampling switch enable.
dacp_top  out  NBITS  P-array cap i bottom plate to VREF.
dacp_btm  out  NBITS  P-array cap i bottom plate to GND.
dacn_top  out  NBITS  N-array cap i bottom plate to VREF.
dacn_btm  out  NBITS  N-array cap i bottom plate to GND.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; bit index, sample counter, average counter and accumulator cleared. Reset mid-conversion aborts at once; the result is lost and sar=0.
- All outputs are registered.
- FSM states: IDLE, SAMPLE, CMP, SETTLE, DONE.
- IDLE: cnvst=1 at an edge → SAMPLE at that edge (edge e0).
- SAMPLE: s_clk=1 for SAMPLE_CYC cycles; all DAC vectors 0 (caps at VCM). Next state is CMP with bit k=NBITS-1 and a cleared working code.
- CMP: cmp_clk=1 for one cycle. At the ending edge, cmp_out is written to code[k].
  - If 1: dacp_btm[k]=1, dacn_top[k]=1.
  - Else: dacp_top[k]=1, dacn_btm[k]=1.
  - Then → SETTLE.
- SETTLE: cmp_clk=0 for one cycle. If k=0 → DONE; else k−1 → CMP.
- eoc timing: DONE is entered SAMPLE_CYC+2·NBITS edges after e0 (18 for the defaults).
- DONE, 1 cycle:
  - Accumulator += code (width NBITS+AVG_LOG2, no overflow possible). Average counter +1.
  - If the counter wraps to 0 (always true when AVG_LOG2=0): sar ← (acc+code)>>AVG_LOG2 (truncating), eoc=1, accumulator cleared.
  - Next state: SAMPLE if (average group incomplete) or cont=1; else IDLE.
  - DAC vectors clear on entering SAMPLE.
- DAC vectors hold their final pattern in IDLE until the next SAMPLE.
- Continuous period: SAMPLE_CYC+2·NBITS+1 cycles per conversion.
- cnvst is ignored outside IDLE; no queueing. cnvst held high in IDLE re-triggers every conversion. cont falling ends the stream after the current DONE.
- The top and btm bits of a cap are never both 1.

Decomposition:
- Shared package sar_pkg: FSM state encoding; the helper function computing the accumulator width.
- One natural sub-module, sar_avg_acc: accumulator, average counter, shift-out of sar, and the eoc pulse.
- FSM, counters and DAC drive stay in the top level.

Test Plan:
1. Reset: rst=1 for 3 cycles, then release → all outputs 0, busy=0, state IDLE; nothing happens without cnvst.
2. Defaults, cmp_out=1 constant, 1-cycle cnvst pulse → s_clk high 2 cycles, then 8 one-cycle cmp_clk pulses 2 cycles apart. eoc 18 edges after the start edge with sar=8'hFF; dacp_btm=dacn_top=8'hFF, dacp_top=dacn_btm=0.
3. Behavioural comparator model with Vin code 8'h5A → sar=8'h5A; dacp_btm=dacn_top=8'h5A, dacp_top=dacn_btm=8'hA5; top&btm=0 checked every cycle.
4. cont=1 plus extra cnvst pulses mid-conversion → eoc every 19 cycles with no extra conversions. Drop cont → exactly one more eoc, then busy=0.
5. rst pulse during the CMP of bit 4 → outputs 0 immediately (asynchronous). A subsequent cnvst gives a full correct conversion.
6. AVG_LOG2=2, model codes 10, 11, 12, 13 → single eoc after 4·19−1 cycles with sar=11 (46>>2). No eoc on the intermediate conversions.
